// File: rtl/adc_capture_controller_if.sv
// Signal bundle between the ADC capture engine and its surroundings:
// the ADC AXI-Stream sink, the timestamp/arming controls, and the
// software read port with its status flags.
`timescale 1ns/1ps
interface adc_capture_controller_if #(
  parameter int AXIS_DATA_WIDTH = 256,
  parameter int BUF_ADDR_WIDTH  = 10,
  parameter int COUNT_WIDTH     = 16
);
  logic [AXIS_DATA_WIDTH-1:0] s00_axis_tdata;
  logic                       s00_axis_tvalid;
  logic                       s00_axis_tready;
  logic [63:0]                counter;
  logic                       arm;
  logic [63:0]                start_time;
  logic [COUNT_WIDTH-1:0]     sample_count;
  logic                       abort;
  logic                       flush;
  logic                       rd_en;
  logic [AXIS_DATA_WIDTH-1:0] rd_data;
  logic                       rd_valid;
  logic [BUF_ADDR_WIDTH:0]    level;
  logic                       empty;
  logic                       busy;
  logic                       done;
  logic                       late;
  logic                       overflow;

  // Stream source, time controller and software side.
  modport master (
    output s00_axis_tdata, s00_axis_tvalid, counter, arm, start_time,
           sample_count, abort, flush, rd_en,
    input  s00_axis_tready, rd_data, rd_valid, level, empty, busy, done,
           late, overflow
  );

  // Capture engine.
  modport slave (
    input  s00_axis_tdata, s00_axis_tvalid, counter, arm, start_time,
           sample_count, abort, flush, rd_en,
    output s00_axis_tready, rd_data, rd_valid, level, empty, busy, done,
           late, overflow
  );
endinterface

// File: rtl/adc_capture_controller.sv
// Timestamp-gated ADC capture engine. Once armed, it writes a programmed
// number of stream beats into a block-RAM FIFO starting on the first cycle
// the global time counter reaches the programmed start time. Software
// drains the FIFO through a pop port with one cycle of read latency.
`timescale 1ns/1ps
module adc_capture_controller #(
  parameter int AXIS_DATA_WIDTH = 256,
  parameter int BUF_DEPTH       = 1024,
  parameter int BUF_ADDR_WIDTH  = 10,
  parameter int COUNT_WIDTH     = 16
) (
  input logic                     clk,
  input logic                     reset,
  adc_capture_controller_if.slave bus
);

  localparam int LVL_W = BUF_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [63:0]                start_q;
  logic [COUNT_WIDTH-1:0]     remaining_q, remaining_d;
  logic [BUF_ADDR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]           level_q, level_d;
  logic                       late_q, overflow_q;
  logic                       rd_valid_q;
  logic [AXIS_DATA_WIDTH-1:0] rd_data_q;
  logic                       tready_q;
  logic [AXIS_DATA_WIDTH-1:0] mem [BUF_DEPTH];

  logic idle_like, arm_ok, start_hit, window, take, full;
  logic wr_en, drop, flush_ok, pop, last_beat;
  logic fsm_busy, fsm_done;

  // Event decode shared by the FSM and the buffer datapath. A beat that
  // coincides with abort is discarded, and fullness is judged before any
  // same-cycle pop so a full buffer never accepts a write.
  always_comb begin
    idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    arm_ok    = bus.arm && idle_like && (bus.sample_count != '0);
    start_hit = (bus.counter >= start_q);
    window    = !bus.abort &&
                (((state_q == S_ARMED) && start_hit) || (state_q == S_CAPTURE));
    take      = window && bus.s00_axis_tvalid;
    full      = (level_q == LVL_W'(BUF_DEPTH));
    wr_en     = take && !full;
    drop      = take && full;
    flush_ok  = bus.flush && idle_like;
    pop       = bus.rd_en && (level_q != '0) && !flush_ok;
    last_beat = take && (remaining_q == COUNT_WIDTH'(1));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: arming, start-time gate, end of window and abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_ok) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (bus.abort)      state_d = S_IDLE;
        else if (last_beat) state_d = S_DONE;
        else if (start_hit) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (bus.abort)      state_d = S_IDLE;
        else if (last_beat) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    fsm_busy = 1'b0;
    fsm_done = 1'b0;
    case (state_q)
      S_ARMED, S_CAPTURE: fsm_busy = 1'b1;
      S_DONE:             fsm_done = 1'b1;
      default: ;
    endcase
  end

  // Beat countdown: loaded on arm, decremented for every accepted-or-dropped
  // beat so the capture window length stays tied to the stream, not the buffer.
  always_comb begin
    remaining_d = remaining_q;
    if (arm_ok)    remaining_d = bus.sample_count;
    else if (take) remaining_d = remaining_q - COUNT_WIDTH'(1);
  end

  // Occupancy: flush clears, otherwise net of write and pop.
  always_comb begin
    level_d = level_q;
    if (flush_ok) begin
      level_d = '0;
    end else begin
      if (wr_en) level_d = level_d + LVL_W'(1);
      if (pop)   level_d = level_d - LVL_W'(1);
    end
  end

  // Control registers: pointers, occupancy, countdown, sticky flags, handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      remaining_q <= '0;
      late_q      <= 1'b0;
      overflow_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      tready_q    <= 1'b0;
    end else begin
      tready_q    <= 1'b1;
      remaining_q <= remaining_d;
      level_q     <= level_d;
      rd_valid_q  <= pop;
      if (flush_ok) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + BUF_ADDR_WIDTH'(1);
        if (pop)   rd_ptr_q <= rd_ptr_q + BUF_ADDR_WIDTH'(1);
      end
      if (arm_ok) begin
        late_q     <= (bus.counter > bus.start_time);
        overflow_q <= 1'b0;
      end else if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Start timestamp captured on arm; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (arm_ok) start_q <= bus.start_time;
  end

  // Buffer write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= bus.s00_axis_tdata;
  end

  // Registered buffer read; holds the last popped beat between pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (pop) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  assign bus.s00_axis_tready = tready_q;
  assign bus.rd_data         = rd_data_q;
  assign bus.rd_valid        = rd_valid_q;
  assign bus.level           = level_q;
  assign bus.empty           = (level_q == '0);
  assign bus.busy            = fsm_busy;
  assign bus.done            = fsm_done;
  assign bus.late            = late_q;
  assign bus.overflow        = overflow_q;

endmodule

// File: tb/tb_adc_capture_controller.sv
// Bench for adc_capture_controller: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-based behavioural model of the capture engine.
`timescale 1ns/1ps
module tb_adc_capture_controller;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adc_capture_controller_if #(.AXIS_DATA_WIDTH(DW), .BUF_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

  adc_capture_controller #(
    .AXIS_DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .BUF_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 waiting for start time, 2 capturing, 3 finished
  int          m_mode = 0;
  logic [63:0] m_start = '0;
  int          m_rem = 0;
  logic [63:0] m_q[$];
  logic        m_late = 0, m_ovf = 0, m_rv = 0, m_tready = 0;
  logic [63:0] m_rd = '0;
  bit          m_live = 0;

  initial begin
    bit idle, fl, take, was_full;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_mode = 0; m_q.delete(); m_late = 0; m_ovf = 0; m_rv = 0;
        m_rd = '0; m_tready = 0; m_rem = 0;
      end else begin
        idle     = (m_mode == 0) || (m_mode == 3);
        fl       = bus.flush && idle;
        take     = !bus.abort && bus.s00_axis_tvalid &&
                   ((m_mode == 1 && bus.counter >= m_start) || m_mode == 2);
        was_full = (m_q.size() == DEPTH);
        m_tready = 1;
        m_rv     = 0;
        if (fl) m_q.delete();
        else if (bus.rd_en && m_q.size() > 0) begin
          m_rd = m_q.pop_front();
          m_rv = 1;
        end
        if (take) begin
          if (was_full) m_ovf = 1;
          else m_q.push_back(bus.s00_axis_tdata);
          m_rem--;
        end
        if (idle) begin
          if (bus.arm && bus.sample_count != 0) begin
            m_mode  = 1;
            m_start = bus.start_time;
            m_rem   = int'(bus.sample_count);
            m_late  = (bus.counter > bus.start_time);
            m_ovf   = 0;
          end
        end else if (bus.abort) m_mode = 0;
        else if (take && m_rem == 0) m_mode = 3;
        else if (m_mode == 1 && bus.counter >= m_start) m_mode = 2;
      end
      m_live = 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        cmp("tready",   bus.s00_axis_tready, m_tready);
        cmp("busy",     bus.busy, (m_mode == 1 || m_mode == 2));
        cmp("done",     bus.done, (m_mode == 3));
        cmp("late",     bus.late, m_late);
        cmp("overflow", bus.overflow, m_ovf);
        cmp("level",    bus.level, 64'(m_q.size()));
        cmp("empty",    bus.empty, (m_q.size() == 0));
        cmp("rd_valid", bus.rd_valid, m_rv);
        cmp("rd_data",  bus.rd_data, m_rd);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    bus.counter        = bus.counter + 64'd1;
    bus.s00_axis_tdata = bus.counter;
    bus.arm   = 1'b0;
    bus.abort = 1'b0;
    bus.flush = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic set_cnt(input logic [63:0] v);
    bus.counter        = v;
    bus.s00_axis_tdata = v;
  endtask

  task automatic do_arm(input logic [63:0] st, input int n);
    bus.arm          = 1'b1;
    bus.start_time   = st;
    bus.sample_count = CW'(n);
  endtask

  task automatic wait_done(input int bound, input string nm);
    int n = 0;
    while (!bus.done && n < bound) begin
      tick();
      n++;
    end
    if (!bus.done) cmp({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic pop_check(input logic [63:0] exp[$], input string nm);
    int n = exp.size();
    for (int i = 0; i <= n; i++) begin
      tick();
      if (i > 0) begin
        cmp({nm, "_rv"}, bus.rd_valid, 1);
        cmp({nm, "_rd"}, bus.rd_data, exp[i-1]);
      end
      bus.rd_en = (i < n);
    end
  endtask

  task automatic do_flush();
    tick();
    bus.flush = 1'b1;
    tick();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [63:0] exp[$];
    logic [63:0] s;
    int n;
    bit popping;

    bus.counter = '0; bus.s00_axis_tdata = '0; bus.s00_axis_tvalid = 1'b0;
    bus.arm = 0; bus.start_time = '0; bus.sample_count = '0;
    bus.abort = 0; bus.flush = 0; bus.rd_en = 0;

    repeat (3) tick();
    cmp("rst_empty",  bus.empty, 1);
    cmp("rst_level",  bus.level, 0);
    cmp("rst_tready", bus.s00_axis_tready, 0);
    cmp("rst_busy",   bus.busy, 0);
    reset = 1'b0;
    tick();

    // Basic capture: 4 beats from t=100, armed at t=50.
    set_cnt(64'd50);
    bus.s00_axis_tvalid = 1'b1;
    do_arm(64'd100, 4);
    tick();
    cmp("basic_busy", bus.busy, 1);
    wait_done(100, "basic");
    cmp("basic_done_cnt", bus.counter, 64'd104);
    cmp("basic_late", bus.late, 0);
    cmp("basic_level", bus.level, 4);
    exp = '{64'd100, 64'd101, 64'd102, 64'd103};
    pop_check(exp, "basic_pop");

    // Gapped stream: tvalid low at 200 and 202.
    do_flush();
    set_cnt(64'd150);
    do_arm(64'd200, 3);
    n = 0;
    do begin
      tick();
      n++;
      bus.s00_axis_tvalid = !(bus.counter == 64'd200 || bus.counter == 64'd202);
    end while (!bus.done && n < 100);
    cmp("gap_done", bus.done, 1);
    cmp("gap_done_cnt", bus.counter, 64'd205);
    cmp("gap_level", bus.level, 3);
    exp = '{64'd201, 64'd203, 64'd204};
    pop_check(exp, "gap_pop");

    // Late arm: start already passed; first eligible cycle is t=500.
    bus.s00_axis_tvalid = 1'b1;
    do_flush();
    set_cnt(64'd499);
    do_arm(64'd10, 2);
    tick();
    cmp("late_flag", bus.late, 1);
    wait_done(20, "late");
    cmp("late_level", bus.level, 2);
    exp = '{64'd500, 64'd501};
    pop_check(exp, "late_pop");

    // Overflow: 20 beats into a 16-deep buffer, no reads.
    do_flush();
    s = bus.counter + 64'd3;
    do_arm(s, 20);
    tick();
    wait_done(60, "ovf");
    cmp("ovf_done_cnt", bus.counter, s + 64'd20);
    cmp("ovf_level", bus.level, 16);
    cmp("ovf_flag", bus.overflow, 1);
    exp.delete();
    for (int i = 0; i < 16; i++) exp.push_back(s + 64'(i));
    pop_check(exp, "ovf_pop");
    tick();
    bus.rd_en = 1'b1;
    tick();
    cmp("empty_rd_valid", bus.rd_valid, 0);
    cmp("empty_flag", bus.empty, 1);

    // Abort after 5 beats, flush ignored while armed, zero-count arm ignored.
    do_flush();
    do_arm(bus.counter + 64'd2, 10);
    n = 0;
    do begin tick(); n++; end while (bus.level != 5 && n < 40);
    bus.abort = 1'b1;
    tick();
    cmp("abort_busy", bus.busy, 0);
    cmp("abort_level", bus.level, 5);
    do_arm(bus.counter + 64'd100, 3);
    tick();
    cmp("armed_busy", bus.busy, 1);
    bus.flush = 1'b1;
    tick();
    cmp("armed_flush_level", bus.level, 5);
    bus.abort = 1'b1;
    tick();
    bus.flush = 1'b1;
    tick();
    cmp("idle_flush_level", bus.level, 0);
    cmp("idle_flush_empty", bus.empty, 1);
    do_arm(bus.counter, 0);
    tick();
    cmp("zero_arm_busy", bus.busy, 0);

    // Pop every cycle during capture once level reaches 1.
    do_arm(bus.counter + 64'd2, 8);
    popping = 0;
    n = 0;
    do begin
      tick();
      n++;
      if (popping) cmp("conc_level", bus.level, 1);
      if (bus.level == 1) popping = 1;
      bus.rd_en = popping;
    end while (!bus.done && n < 40);
    cmp("conc_done", bus.done, 1);

    // Reset in the middle of a late capture.
    tick();
    do_arm(bus.counter - 64'd5, 10);
    repeat (4) tick();
    cmp("mid_late_pre", bus.late, 1);
    reset = 1'b1;
    tick();
    cmp("mid_rst_busy", bus.busy, 0);
    cmp("mid_rst_late", bus.late, 0);
    cmp("mid_rst_level", bus.level, 0);
    cmp("mid_rst_empty", bus.empty, 1);
    cmp("mid_rst_rd_data", bus.rd_data, 0);
    reset = 1'b0;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      tick();
      reset = ($urandom_range(0, 799) == 0);
      bus.s00_axis_tvalid = ($urandom_range(0, 9) < 7);
      bus.rd_en = ($urandom_range(0, 99) < (((i / 400) % 2) != 0 ? 85 : 15));
      bus.arm = ($urandom_range(0, 19) == 0);
      bus.sample_count = CW'($urandom_range(0, 24));
      bus.start_time = bus.counter + 64'($urandom_range(0, 25)) - 64'd5;
      bus.abort = ($urandom_range(0, 149) == 0);
      bus.flush = ($urandom_range(0, 99) == 0);
    end
    reset = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
